id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand forwarding. It drives alu32 directly on a,b,f,shamt.
//  - Latches decoded operands and control from ID.
//  - Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
//  - Flags load-use hazards back to the IF/ID hazard logic.
// PARAMETERS
//  XLEN   32  datapath width (alu32 operand width)
//  RIDX    5  register index width
// PORTS
//  clk            in   1     rising-edge clock
//  reset          in   1     synchronous, active-high
//  stall          in   1     hold all ID/EX state (downstream busy)
//  flush          in   1     squash ID/EX contents (branch taken)
//  id_valid       in   1     ID holds a real instruction
//  id_rs,id_rt,id_rd in RIDX source/dest indices
//  id_rs_data,id_rt_data in XLEN register-file read data
//  id_imm         in   XLEN  sign-extended immediate
//  id_shamt       in   5     shift amount
//  id_alu_f       in   4     ALU function code (mips_pkg ALU_F_*)
//  id_alusrc,id_regdst,id_regwrite,id_memread,id_memwrite,id_memtoreg in 1 control bits
//  exmem_regwrite in 1; exmem_rd in RIDX; exmem_y in XLEN    EX/MEM result
//  memwb_regwrite in 1; memwb_rd in RIDX; memwb_wd in XLEN   MEM/WB writeback
//  alu_a,alu_b    out  XLEN  to alu32 a,b
//  alu_f          out  4     to alu32 f
//  alu_shamt      out  5     to alu32 shamt
//  ex_store_data  out  XLEN  forwarded rt value for SW
//  ex_wreg        out  RIDX  destination: regdst ? rd : rt
//  ex_valid,ex_regwrite,ex_memread,ex_memwrite,ex_memtoreg out 1
//  hazard_o       out  1     load-use (or RAW, see CONFIG) stall request to IF/ID
// BEHAVIOUR
//  Update priority at posedge clk: reset > flush > bubble > stall > load.
//  - reset: every register is 0. Outputs: ex_valid and all ctrl 0; alu_f, alu_shamt and ex_wreg 0; alu_a, alu_b and ex_store_data 0.
//  - flush: the stage becomes a bubble: valid and ctrl regs 0, data regs don't-care. Flush wins over stall.
//  - bubble: hazard_o=1 and !stall loads a bubble. IF/ID holds, so the dependent instruction re-presents next cycle.
//  - stall=1: all regs hold. hazard_o is still evaluated but forces no bubble.
//  - load: capture all id_* inputs. Ctrl bits are ANDed with id_valid.
//  Latency: 1 cycle ID->EX outputs. Forwarding is combinational in the same cycle.
//  Forwarding for operand A, using the registered ex_rs; B uses ex_rt identically:
//  - exmem_regwrite && exmem_rd!=0 && exmem_rd==ex_rs -> exmem_y
//  - else memwb_regwrite && memwb_rd!=0 && memwb_rd==ex_rs -> memwb_wd
//  - else the registered rs_data
//  - EX/MEM has priority over MEM/WB (newest value). Register 0 is never forwarded.
//  Operand B: alu_b = ex_alusrc ? ex_imm : fwd_rt. ex_store_data = fwd_rt always.
//  hazard_o = ex_valid & ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt) & id_valid.
//  ex_wreg is computed at load time, then registered.
//  Register-file write-before-read in WB is external; this block relies on it.
// CONFIGURATION
//  FORWARDING_EN defined: forwarding as above.
//  FORWARDING_EN undefined:
//  - Muxes removed: alu_a = rs_data; fwd_rt = rt_data.
//  - hazard_o additionally asserts when id_rs or id_rt (nonzero, id_valid) matches either ex_wreg (ex_regwrite & ex_valid) or exmem_rd (exmem_regwrite).
//  - Bubbles are inserted until the producer reaches WB.
// STRUCTURE
//  mips_pkg:
//  - XLEN, RIDX and the ALU_F_* codes.
//  - typedef fwd_sel_t {FWD_REG, FWD_EXMEM, FWD_MEMWB}.
//  - typedef ex_ctrl_t, a packed struct of the 5 ctrl bits.
//  Sub-module fwd_mux: select logic plus 3:1 mux, one instance per operand.
//  It is compiled only under FORWARDING_EN.
// TESTING
//  1. Reset then load ADD, rs=1 (data 5), rt=2 (data 7), no hazards.
//     -> next cycle alu_a=5, alu_b=7, ex_valid=1.
//  2. EX/MEM forward: ex_rs=3, exmem_rd=3, exmem_regwrite=1, exmem_y=0x1234, memwb_rd=3, memwb_wd=0x9999.
//     -> alu_a=0x1234 (EX/MEM priority).
//  3. R0 guard: ex_rt=0, exmem_rd=0, exmem_regwrite=1, exmem_y=0xFFFFFFFF, rt_data=0, alusrc=0.
//     -> alu_b=0.
//  4. Load-use: EX holds LW with rt=4; ID instr rs=4.
//     -> hazard_o=1; next cycle ex_valid=0 and ex_regwrite=0; the re-presented instr loads after.
//  5. flush=1 with stall=1 on a valid instr.
//     -> next cycle ex_valid=0 and all ctrl 0. stall=1 alone -> all outputs unchanged over 3 cycles.
//  6. reset asserted mid-stream with valid contents.
//     -> next edge all outputs 0. Without FORWARDING_EN, case 2 yields hazard_o=1 instead.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths, ALU function codes and EX-stage types for the ID/EX slice.
package mips_pkg;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    localparam logic [3:0] ALU_F_AND = 4'd0;
    localparam logic [3:0] ALU_F_OR  = 4'd1;
    localparam logic [3:0] ALU_F_ADD = 4'd2;
    localparam logic [3:0] ALU_F_SLL = 4'd3;
    localparam logic [3:0] ALU_F_SRL = 4'd4;
    localparam logic [3:0] ALU_F_SRA = 4'd5;
    localparam logic [3:0] ALU_F_SUB = 4'd6;
    localparam logic [3:0] ALU_F_SLT = 4'd7;
    localparam logic [3:0] ALU_F_NOR = 4'd12;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic alusrc;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } ex_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select plus 3:1 data mux (only built with FORWARDING_EN).
`ifdef FORWARDING_EN
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DW = XLEN,
    parameter int RW = RIDX
) (
    input  logic [RW-1:0] i_src,
    input  logic [DW-1:0] i_reg_data,
    input  logic          i_exmem_regwrite,
    input  logic [RW-1:0] i_exmem_rd,
    input  logic [DW-1:0] i_exmem_y,
    input  logic          i_memwb_regwrite,
    input  logic [RW-1:0] i_memwb_rd,
    input  logic [DW-1:0] i_memwb_wd,
    output logic [DW-1:0] o_data
);

    fwd_sel_t w_sel;

    // EX/MEM is checked first because it carries the newest value; r0 is never forwarded.
    always_comb begin
        w_sel = FWD_REG;
        if (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_src))
            w_sel = FWD_EXMEM;
        else if (i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_src))
            w_sel = FWD_MEMWB;
    end

    always_comb begin
        case (w_sel)
            FWD_EXMEM: o_data = i_exmem_y;
            FWD_MEMWB: o_data = i_memwb_wd;
            default:   o_data = i_reg_data;
        endcase
    end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use hazard detection.
// Build option: FORWARDING_EN enables the forwarding muxes; without it RAW hazards stall instead.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = XLEN,
    parameter int RW = RIDX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [3:0]    id_alu_f,
    input  logic          id_alusrc,
    input  logic          id_regdst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_y,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_wd,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_f,
    output logic [4:0]    alu_shamt,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wreg,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          hazard_o
);

    logic          r_valid;
    ex_ctrl_t      r_ctrl;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [RW-1:0] r_wreg;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_imm;
    logic [4:0]    r_shamt;
    logic [3:0]    r_alu_f;

    ex_ctrl_t      w_id_ctrl;
    logic          w_load_use;
    logic          w_hazard;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

    assign w_id_ctrl = '{
        alusrc:   id_alusrc   & id_valid,
        regwrite: id_regwrite & id_valid,
        memread:  id_memread  & id_valid,
        memwrite: id_memwrite & id_valid,
        memtoreg: id_memtoreg & id_valid
    };

    // A bubble clears only valid/ctrl; the data registers are don't-care in a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_wreg    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_shamt   <= '0;
            r_alu_f   <= '0;
        end else if (flush || (w_hazard && !stall)) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (!stall) begin
            r_valid   <= id_valid;
            r_ctrl    <= w_id_ctrl;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_wreg    <= id_regdst ? id_rd : id_rt;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_shamt   <= id_shamt;
            r_alu_f   <= id_alu_f;
        end
    end

    assign w_load_use = r_valid & r_ctrl.memread & (r_rt != '0)
                      & ((r_rt == id_rs) | (r_rt == id_rt)) & id_valid;

`ifdef FORWARDING_EN
    logic [RW-1:0] w_src  [2];
    logic [DW-1:0] w_reg  [2];
    logic [DW-1:0] w_fwd  [2];

    assign w_src[0] = r_rs;
    assign w_src[1] = r_rt;
    assign w_reg[0] = r_rs_data;
    assign w_reg[1] = r_rt_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_mux #(.DW(DW), .RW(RW)) u_fwd (
                .i_src            (w_src[gi]),
                .i_reg_data       (w_reg[gi]),
                .i_exmem_regwrite (exmem_regwrite),
                .i_exmem_rd       (exmem_rd),
                .i_exmem_y        (exmem_y),
                .i_memwb_regwrite (memwb_regwrite),
                .i_memwb_rd       (memwb_rd),
                .i_memwb_wd       (memwb_wd),
                .o_data           (w_fwd[gi])
            );
        end
    endgenerate

    assign w_fwd_rs = w_fwd[0];
    assign w_fwd_rt = w_fwd[1];
    assign w_hazard = w_load_use;
`else
    logic w_raw;
    logic w_unused_fwd;

    // Without forwarding, any in-flight producer in EX or MEM forces a bubble until it reaches WB.
    always_comb begin
        w_raw = 1'b0;
        if (id_valid) begin
            if ((id_rs != '0) &&
                ((r_valid && r_ctrl.regwrite && (id_rs == r_wreg)) ||
                 (exmem_regwrite && (id_rs == exmem_rd))))
                w_raw = 1'b1;
            if ((id_rt != '0) &&
                ((r_valid && r_ctrl.regwrite && (id_rt == r_wreg)) ||
                 (exmem_regwrite && (id_rt == exmem_rd))))
                w_raw = 1'b1;
        end
    end

    assign w_fwd_rs     = r_rs_data;
    assign w_fwd_rt     = r_rt_data;
    assign w_hazard     = w_load_use | w_raw;
    assign w_unused_fwd = ^{exmem_y, memwb_regwrite, memwb_rd, memwb_wd};
`endif

    assign alu_a         = w_fwd_rs;
    assign alu_b         = r_ctrl.alusrc ? r_imm : w_fwd_rt;
    assign alu_f         = r_alu_f;
    assign alu_shamt     = r_shamt;
    assign ex_store_data = w_fwd_rt;
    assign ex_wreg       = r_wreg;
    assign ex_valid      = r_valid;
    assign ex_regwrite   = r_ctrl.regwrite;
    assign ex_memread    = r_ctrl.memread;
    assign ex_memwrite   = r_ctrl.memwrite;
    assign ex_memtoreg   = r_ctrl.memtoreg;
    assign hazard_o      = w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver queues expected values per cycle, a negedge monitor checks them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_alu_f;
    logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_y, memwb_wd;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_f;
    logic [4:0]  alu_shamt, ex_wreg;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, hazard_o;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alu_f(id_alu_f),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_y(exmem_y),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wd(memwb_wd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_shamt(alu_shamt),
        .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .hazard_o(hazard_o)
    );

    always #5 clk = ~clk;

    localparam int S_A = 0, S_B = 1, S_VALID = 2, S_CTRL = 3, S_HAZ = 4,
                   S_WREG = 5, S_STORE = 6, S_ALUF = 7, S_SHAMT = 8;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] actual(int sig);
        case (sig)
            S_A:     return alu_a;
            S_B:     return alu_b;
            S_VALID: return {31'd0, ex_valid};
            S_CTRL:  return {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg};
            S_HAZ:   return {31'd0, hazard_o};
            S_WREG:  return {27'd0, ex_wreg};
            S_STORE: return ex_store_data;
            S_ALUF:  return {28'd0, alu_f};
            default: return {27'd0, alu_shamt};
        endcase
    endfunction

    // Monitor: compare every queued expectation that falls due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] got;
            e   = sb.pop_front();
            got = actual(e.sig);
            n_cmp++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: check due cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (got !== e.val) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", e.name, cyc, got, e.val);
            end else begin
                $display("ok   %s @cyc %0d: 0x%08h", e.name, cyc, got);
            end
        end
    end

    task automatic expect_v(input int sig, input string name, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.sig = sig; e.val = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [4:0] sh, input logic [3:0] f,
                          input logic [5:0] c);
        // c = {alusrc, regdst, regwrite, memread, memwrite, memtoreg}
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh; id_alu_f = f;
        {id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg} = c;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ey,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mwd);
        exmem_regwrite = ew; exmem_rd = erd; exmem_y = ey;
        memwb_regwrite = mw; memwb_rd = mrd; memwb_wd = mwd;
    endtask

    task automatic expect_zero(input string tag);
        expect_v(S_A,     {tag, "_alu_a"}, 32'h0);
        expect_v(S_B,     {tag, "_alu_b"}, 32'h0);
        expect_v(S_VALID, {tag, "_valid"}, 32'h0);
        expect_v(S_CTRL,  {tag, "_ctrl"},  32'h0);
        expect_v(S_WREG,  {tag, "_wreg"},  32'h0);
        expect_v(S_STORE, {tag, "_store"}, 32'h0);
        expect_v(S_ALUF,  {tag, "_aluf"},  32'h0);
        expect_v(S_SHAMT, {tag, "_shamt"}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(1'b1, 5'd7, 5'd6, 5'd5, 32'hAA, 32'hBB, 32'hC, 5'd4, 4'd2, 6'b111111);
        set_fwd(1'b1, 5'd7, 32'hDEAD, 1'b1, 5'd6, 32'hBEEF);
        step(); step();
        expect_zero("reset");
        expect_v(S_HAZ, "reset_hazard", 32'h0);

        // 1: plain ADD, rs=1 (5), rt=2 (7), rd=9
        reset = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 32'h10, 5'd3, 4'd2, 6'b011000);
        step();
        expect_v(S_A, "add_alu_a", 32'd5);
        expect_v(S_B, "add_alu_b", 32'd7);
        expect_v(S_VALID, "add_valid", 32'd1);
        expect_v(S_CTRL, "add_ctrl", 32'b1000);
        expect_v(S_WREG, "add_wreg", 32'd9);
        expect_v(S_ALUF, "add_aluf", 32'd2);
        expect_v(S_SHAMT, "add_shamt", 32'd3);
        expect_v(S_STORE, "add_store", 32'd7);

        // 2: EX/MEM vs MEM/WB on rs=3
        set_id(1'b1, 5'd3, 5'd5, 5'd6, 32'h11, 32'h22, 32'h0, 5'd0, 4'd2, 6'b011000);
        expect_v(S_HAZ, "add_hazard", 32'h0);
        step();
        set_fwd(1'b1, 5'd3, 32'h1234, 1'b1, 5'd3, 32'h9999);
        expect_v(S_B, "exmem_alu_b", 32'h22);
`ifdef FORWARDING_EN
        expect_v(S_A, "exmem_alu_a", 32'h1234);
        expect_v(S_HAZ, "exmem_hazard", 32'h0);
`else
        expect_v(S_A, "exmem_alu_a", 32'h11);
        expect_v(S_HAZ, "exmem_hazard", 32'h1);
`endif
        step();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h5555);
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'hA, 32'h0, 32'h0, 5'd0, 4'd6, 6'b000000);
`ifdef FORWARDING_EN
        expect_v(S_VALID, "memwb_valid", 32'd1);
        expect_v(S_A, "memwb_alu_a", 32'h11);
        expect_v(S_B, "memwb_alu_b", 32'h5555);
        expect_v(S_STORE, "memwb_store", 32'h5555);
`else
        expect_v(S_VALID, "raw_bubble_valid", 32'd0);
        expect_v(S_CTRL, "raw_bubble_ctrl", 32'd0);
`endif
        expect_v(S_HAZ, "memwb_hazard", 32'h0);

        // 3: r0 is never forwarded
        step();
        set_fwd(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hEEEE);
        expect_v(S_B, "r0_alu_b", 32'h0);
        expect_v(S_STORE, "r0_store", 32'h0);
        expect_v(S_A, "r0_alu_a", 32'hA);
        expect_v(S_WREG, "r0_wreg", 32'h0);
        expect_v(S_ALUF, "r0_aluf", 32'd6);
        expect_v(S_CTRL, "r0_ctrl", 32'h0);
        set_id(1'b1, 5'd1, 5'd4, 5'd0, 32'h100, 32'h77, 32'h8, 5'd0, 4'd2, 6'b101101);
        expect_v(S_HAZ, "r0_hazard", 32'h0);

        // 4: LW rt=4 in EX, dependent rs=4 in ID
        step();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_v(S_A, "lw_alu_a", 32'h100);
        expect_v(S_B, "lw_alu_b_imm", 32'h8);
        expect_v(S_STORE, "lw_store", 32'h77);
        expect_v(S_CTRL, "lw_ctrl", 32'b1101);
        expect_v(S_WREG, "lw_wreg", 32'd4);
        set_id(1'b1, 5'd4, 5'd2, 5'd8, 32'h3, 32'h7, 32'h0, 5'd0, 4'd2, 6'b011000);
        expect_v(S_HAZ, "loaduse_hazard", 32'h1);
        step();
        expect_v(S_VALID, "loaduse_bubble_valid", 32'd0);
        expect_v(S_CTRL, "loaduse_bubble_ctrl", 32'd0);
        expect_v(S_HAZ, "loaduse_clear", 32'h0);
        step();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hABCD);
        expect_v(S_VALID, "dep_valid", 32'd1);
        expect_v(S_WREG, "dep_wreg", 32'd8);
        expect_v(S_CTRL, "dep_ctrl", 32'b1000);
        expect_v(S_B, "dep_alu_b", 32'h7);
`ifdef FORWARDING_EN
        expect_v(S_A, "dep_alu_a", 32'hABCD);
`else
        expect_v(S_A, "dep_alu_a", 32'h3);
`endif

        // 5: flush beats stall, then stall alone holds everything
        set_id(1'b1, 5'd2, 5'd3, 5'd10, 32'h50, 32'h60, 32'h0, 5'd0, 4'd1, 6'b011000);
        flush = 1'b1; stall = 1'b1;
        expect_v(S_HAZ, "pre_flush_hazard", 32'h0);
        step();
        expect_v(S_VALID, "flush_valid", 32'd0);
        expect_v(S_CTRL, "flush_ctrl", 32'd0);
        flush = 1'b0; stall = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd7, 5'd6, 5'd5, 32'h70, 32'h60, 32'h123, 5'd9, 4'd1, 6'b011000);
        step();
        stall = 1'b1;
        set_id(1'b1, 5'd2, 5'd3, 5'd12, 32'h99, 32'h98, 32'h0, 5'd1, 4'd7, 6'b010010);
        for (int k = 0; k < 4; k++) begin
            expect_v(S_A, $sformatf("stall%0d_alu_a", k), 32'h70);
            expect_v(S_B, $sformatf("stall%0d_alu_b", k), 32'h60);
            expect_v(S_WREG, $sformatf("stall%0d_wreg", k), 32'd5);
            expect_v(S_CTRL, $sformatf("stall%0d_ctrl", k), 32'b1000);
            expect_v(S_VALID, $sformatf("stall%0d_valid", k), 32'd1);
            expect_v(S_ALUF, $sformatf("stall%0d_aluf", k), 32'd1);
            expect_v(S_SHAMT, $sformatf("stall%0d_shamt", k), 32'd9);
            if (k < 3) step();
        end

        // 6: reset mid-stream
        stall = 1'b0; reset = 1'b1;
        step();
        expect_zero("midreset");
        reset = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 4'd0, 6'b000000);
        step();
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked (due cycle %0d)", e.name, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got %0d checks, required completion", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
